// File: rtl/huff_encoder_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : huff_encoder_param                                            |
// | Function : streaming Huffman encoder for NUM_SYM (symbol, freq) pairs;   |
// |            builds the tree in hardware and emits one code per symbol.    |
// | Option   : HUFF_STATS_EN adds the stat_bits / stat_valid outputs.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module huff_encoder_param #(
   parameter int NUM_SYM = 3,
   parameter int FREQ_W  = 3,
   parameter int SYM_W   = 8,
   parameter int MAX_LEN = NUM_SYM - 1,
   parameter int W_W     = FREQ_W + $clog2(NUM_SYM)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [SYM_W-1:0]                 in_sym,
   input  logic [FREQ_W-1:0]                in_freq,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SYM_W-1:0]                 out_sym,
   output logic [MAX_LEN-1:0]               out_code,
   output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
   output logic                             out_last,
`ifdef HUFF_STATS_EN
   output logic [W_W+$clog2(MAX_LEN+1)-1:0] stat_bits,
   output logic                             stat_valid,
`endif
   output logic                             busy
);

   localparam int c_NODES = 2 * NUM_SYM - 1;
   localparam int c_NI_W  = $clog2(c_NODES);
   localparam int c_SI_W  = $clog2(NUM_SYM);
   localparam int c_LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [c_NI_W-1:0] c_ROOT      = c_NI_W'(c_NODES - 1);
   localparam logic [c_NI_W-1:0] c_LAST_LOAD = c_NI_W'(NUM_SYM - 1);
   localparam logic [c_SI_W-1:0] c_LAST_LEAF = c_SI_W'(NUM_SYM - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_MERGE = 2'd1,
      S_WALK  = 2'd2,
      S_EMIT  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;

   // Node table: leaves at 0..NUM_SYM-1, internal nodes appended in creation order
   logic [W_W-1:0]        r_weight [c_NODES];
   logic [c_NI_W-1:0]     r_parent [c_NODES];
   logic [c_NODES-1:0]    r_active;
   logic [c_NODES-1:0]    r_bit;
   logic [SYM_W-1:0]      r_sym    [NUM_SYM];

   logic [c_NI_W-1:0]     r_cnt;
   logic [c_SI_W-1:0]     r_leaf;
   logic [c_NI_W-1:0]     r_cur;
   logic [MAX_LEN-1:0]    r_code;
   logic [c_LEN_W-1:0]    r_len;

   logic [c_NI_W-1:0]     w_min1;
   logic [c_NI_W-1:0]     w_min2;
   logic [W_W-1:0]        w_min1_w;
   logic [W_W-1:0]        w_min2_w;
   logic                  w_found1;
   logic                  w_found2;
   logic [c_NI_W-1:0]     w_leaf_node;
   logic                  w_is_last;
   logic                  w_hs;

   assign w_leaf_node = {{(c_NI_W-c_SI_W){1'b0}}, r_leaf};
   assign w_is_last   = (r_leaf == c_LAST_LEAF);
   assign w_hs        = out_valid && out_ready;

   // Strict less-than keeps the lowest index on equal weights
   always_comb begin
      w_min1   = '0;
      w_min2   = '0;
      w_min1_w = '0;
      w_min2_w = '0;
      w_found1 = 1'b0;
      w_found2 = 1'b0;
      for (int i = 0; i < c_NODES; i++) begin
         if (r_active[i] && (!w_found1 || r_weight[i] < w_min1_w)) begin
            w_min1   = c_NI_W'(i);
            w_min1_w = r_weight[i];
            w_found1 = 1'b1;
         end
      end
      for (int i = 0; i < c_NODES; i++) begin
         if (r_active[i] && (c_NI_W'(i) != w_min1) &&
             (!w_found2 || r_weight[i] < w_min2_w)) begin
            w_min2   = c_NI_W'(i);
            w_min2_w = r_weight[i];
            w_found2 = 1'b1;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid && r_cnt == c_LAST_LOAD) w_next = S_MERGE;
         end
         S_MERGE: if (r_cnt == c_ROOT) w_next = S_WALK;
         S_WALK:  if (r_parent[r_cur] == c_ROOT) w_next = S_EMIT;
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = w_is_last ? S_LOAD : S_WALK;
         end
         default: w_next = S_LOAD;
      endcase
   end

   assign out_sym  = r_sym[r_leaf];
   assign out_code = r_code;
   assign out_len  = r_len;
   assign out_last = out_valid && w_is_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_LOAD;
         r_cnt    <= '0;
         r_leaf   <= '0;
         r_cur    <= '0;
         r_code   <= '0;
         r_len    <= '0;
         r_active <= '0;
         r_bit    <= '0;
         for (int i = 0; i < c_NODES; i++) begin
            r_weight[i] <= '0;
            r_parent[i] <= '0;
         end
         for (int i = 0; i < NUM_SYM; i++) r_sym[i] <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LOAD: begin
               if (in_valid) begin
                  r_sym[r_cnt[c_SI_W-1:0]] <= in_sym;
                  r_weight[r_cnt]          <= W_W'(in_freq);
                  r_active[r_cnt]          <= 1'b1;
                  r_cnt                    <= r_cnt + 1'b1;
               end
            end
            S_MERGE: begin
               r_weight[r_cnt] <= w_min1_w + w_min2_w;
               r_active[w_min1] <= 1'b0;
               r_active[w_min2] <= 1'b0;
               r_active[r_cnt]  <= 1'b1;
               r_parent[w_min1] <= r_cnt;
               r_parent[w_min2] <= r_cnt;
               r_bit[w_min1]    <= 1'b0;
               r_bit[w_min2]    <= 1'b1;
               r_cnt            <= r_cnt + 1'b1;
               if (r_cnt == c_ROOT) begin
                  r_leaf <= '0;
                  r_cur  <= '0;
               end
            end
            S_WALK: begin
               r_code <= r_code | (MAX_LEN'(r_bit[r_cur]) << r_len);
               r_len  <= r_len + 1'b1;
               r_cur  <= r_parent[r_cur];
            end
            S_EMIT: begin
               if (out_ready) begin
                  r_code <= '0;
                  r_len  <= '0;
                  if (w_is_last) begin
                     r_cnt    <= '0;
                     r_leaf   <= '0;
                     r_active <= '0;
                  end else begin
                     r_leaf <= r_leaf + 1'b1;
                     r_cur  <= w_leaf_node + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HUFF_STATS_EN
   localparam int c_STAT_W = W_W + c_LEN_W;
   logic [c_STAT_W-1:0] r_stat;

   // Adding the leaf frequency once per tree level yields freq*len
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat <= '0;
      end else if (r_state == S_EMIT && out_ready && w_is_last) begin
         r_stat <= '0;
      end else if (r_state == S_WALK) begin
         r_stat <= r_stat + c_STAT_W'(r_weight[w_leaf_node]);
      end
   end

   assign stat_bits  = r_stat;
   assign stat_valid = w_hs && out_last;
`else
   logic w_unused;
   assign w_unused = w_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_huff_encoder_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_huff_encoder_param                                         |
// | Function : scoreboard bench for huff_encoder_param (3- and 4-symbol).    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_huff_encoder_param;

   logic clk;
   logic reset;

   logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, busy3;
   logic [7:0] in_sym3, out_sym3;
   logic [2:0] in_freq3;
   logic [1:0] out_code3, out_len3;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;
   logic [7:0] in_sym4, out_sym4;
   logic [3:0] in_freq4;
   logic [2:0] out_code4;
   logic [1:0] out_len4;

`ifdef HUFF_STATS_EN
   logic [6:0] stat_bits3;
   logic [7:0] stat_bits4;
   logic       stat_valid3, stat_valid4;
   int unsigned qs3[$];
   int unsigned qs4[$];
`endif

   typedef struct {
      logic [7:0] sym;
      logic [7:0] code;
      logic [3:0] len;
      logic       last;
   } rec_t;

   rec_t q3[$];
   rec_t q4[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic bp_en;
   int   stall;

   huff_encoder_param #(.NUM_SYM(3), .FREQ_W(3), .SYM_W(8)) u_dut3 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_sym(in_sym3), .in_freq(in_freq3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_sym(out_sym3),
      .out_code(out_code3), .out_len(out_len3), .out_last(out_last3),
`ifdef HUFF_STATS_EN
      .stat_bits(stat_bits3), .stat_valid(stat_valid3),
`endif
      .busy(busy3)
   );

   huff_encoder_param #(.NUM_SYM(4), .FREQ_W(4), .SYM_W(8)) u_dut4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_sym(in_sym4), .in_freq(in_freq4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_sym(out_sym4),
      .out_code(out_code4), .out_len(out_len4), .out_last(out_last4),
`ifdef HUFF_STATS_EN
      .stat_bits(stat_bits4), .stat_valid(stat_valid4),
`endif
      .busy(busy4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_rec(input string tag, input rec_t e, input logic [7:0] sym,
                            input logic [7:0] code, input logic [3:0] len, input logic last);
      n_cmp++;
      if (sym !== e.sym || code !== e.code || len !== e.len || last !== e.last) begin
         n_fail++;
         $display("FAIL %s: got sym=%h code=%b len=%0d last=%b, want sym=%h code=%b len=%0d last=%b",
                  tag, sym, code, len, last, e.sym, e.code, e.len, e.last);
      end
   endtask

   task automatic push3(input logic [7:0] s, input logic [1:0] c, input logic [3:0] l, input logic last);
      rec_t e;
      e.sym = s; e.code = {6'b0, c}; e.len = l; e.last = last;
      q3.push_back(e);
   endtask

   task automatic push4(input logic [7:0] s, input logic [2:0] c, input logic [3:0] l, input logic last);
      rec_t e;
      e.sym = s; e.code = {5'b0, c}; e.len = l; e.last = last;
      q4.push_back(e);
   endtask

   task automatic push_stat4(input int unsigned v);
`ifdef HUFF_STATS_EN
      qs4.push_back(v);
`else
      if (v == 0) n_cmp = n_cmp;
`endif
   endtask

   // Called at posedge+1; returns at posedge+1 after the final accept.
   task automatic load3(input logic [23:0] syms, input logic [8:0] fr);
      for (int k = 0; k < 3; k++) begin
         int g;
         g = 0;
         in_valid3 = 1'b1; in_sym3 = syms[8*k +: 8]; in_freq3 = fr[3*k +: 3];
         @(negedge clk);
         while (!in_ready3 && g < 300) begin @(negedge clk); g++; end
         if (g >= 300) begin n_cmp++; n_fail++; $display("FAIL load3: in_ready timeout"); end
         @(posedge clk); #1;
      end
      in_valid3 = 1'b0;
   endtask

   task automatic load4(input logic [31:0] syms, input logic [15:0] fr);
      for (int k = 0; k < 4; k++) begin
         int g;
         g = 0;
         in_valid4 = 1'b1; in_sym4 = syms[8*k +: 8]; in_freq4 = fr[4*k +: 4];
         @(negedge clk);
         while (!in_ready4 && g < 300) begin @(negedge clk); g++; end
         if (g >= 300) begin n_cmp++; n_fail++; $display("FAIL load4: in_ready timeout"); end
         @(posedge clk); #1;
      end
      in_valid4 = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q3.size() != 0 || q4.size() != 0) && g < 2000) begin @(negedge clk); g++; end
      chk("drain_timeout", (g >= 2000) ? 32'd1 : 32'd0, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready3"}, {31'b0, in_ready3}, 32'd1);
      chk({tag, "_out_valid3"}, {31'b0, out_valid3}, 32'd0);
      chk({tag, "_busy3"}, {31'b0, busy3}, 32'd0);
      chk({tag, "_in_ready4"}, {31'b0, in_ready4}, 32'd1);
      chk({tag, "_out_valid4"}, {31'b0, out_valid4}, 32'd0);
      chk({tag, "_out_sym4"}, {24'b0, out_sym4}, 32'd0);
      chk({tag, "_out_code4"}, {29'b0, out_code4}, 32'd0);
      chk({tag, "_out_len4"}, {30'b0, out_len4}, 32'd0);
      chk({tag, "_out_last4"}, {31'b0, out_last4}, 32'd0);
      chk({tag, "_busy4"}, {31'b0, busy4}, 32'd0);
   endtask

   // Downstream model: optional 5-cycle stall on every record of u_dut4
   initial begin
      out_ready3 = 1'b1;
      out_ready4 = 1'b1;
      stall = 0;
      forever begin
         @(posedge clk); #1;
         if (!bp_en) begin
            out_ready4 = 1'b1;
            stall = 0;
         end else if (out_valid4 && !out_ready4) begin
            stall++;
            if (stall >= 5) out_ready4 = 1'b1;
         end else begin
            out_ready4 = 1'b0;
            stall = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL rec3: unexpected record sym=%h", out_sym3);
            end else begin
               check_rec("rec3", q3.pop_front(), out_sym3, {6'b0, out_code3}, {2'b0, out_len3}, out_last3);
            end
         end
`ifdef HUFF_STATS_EN
         if (stat_valid3) begin
            if (qs3.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL stat3: unexpected pulse");
            end else chk("stat3", {25'b0, stat_bits3}, qs3.pop_front());
         end
`endif
      end
   end

   rec_t m4_prev;
   logic m4_pend = 1'b0;
   logic m4_lasths = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         m4_pend   = 1'b0;
         m4_lasths = 1'b0;
      end else begin
         if (m4_pend) begin
            n_cmp++;
            if (!out_valid4 || out_sym4 !== m4_prev.sym || {5'b0, out_code4} !== m4_prev.code ||
                {2'b0, out_len4} !== m4_prev.len || out_last4 !== m4_prev.last) begin
               n_fail++;
               $display("FAIL hold4: got valid=%b sym=%h code=%b len=%0d, want valid=1 sym=%h code=%b len=%0d",
                        out_valid4, out_sym4, out_code4, out_len4, m4_prev.sym, m4_prev.code, m4_prev.len);
            end
         end
         if (m4_lasths) chk("in_ready_after_last4", {31'b0, in_ready4}, 32'd1);
         m4_lasths = 1'b0;
         if (out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL rec4: unexpected record sym=%h", out_sym4);
            end else begin
               check_rec("rec4", q4.pop_front(), out_sym4, {5'b0, out_code4}, {2'b0, out_len4}, out_last4);
            end
            m4_lasths = out_last4;
         end
`ifdef HUFF_STATS_EN
         if (stat_valid4) begin
            if (qs4.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL stat4: unexpected pulse");
            end else chk("stat4", {24'b0, stat_bits4}, qs4.pop_front());
         end
`endif
         m4_pend      = out_valid4 && !out_ready4;
         m4_prev.sym  = out_sym4;
         m4_prev.code = {5'b0, out_code4};
         m4_prev.len  = {2'b0, out_len4};
         m4_prev.last = out_last4;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; bp_en = 1'b0;
      in_valid3 = 1'b0; in_sym3 = '0; in_freq3 = '0;
      in_valid4 = 1'b0; in_sym4 = '0; in_freq4 = '0;
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset_vals("por");
      @(posedge clk); #1;
      reset = 1'b0;

      // 3-symbol batch: a=4, n=2, m=2
      push3("a", 2'b00, 4'd1, 1'b0);
      push3("n", 2'b10, 4'd2, 1'b0);
      push3("m", 2'b11, 4'd2, 1'b1);
`ifdef HUFF_STATS_EN
      qs3.push_back(12);
`endif
      load3({"m", "n", "a"}, {3'd2, 3'd2, 3'd4});
      drain();

      // Equal frequencies
      push4("A", 3'b000, 4'd2, 1'b0);
      push4("B", 3'b001, 4'd2, 1'b0);
      push4("C", 3'b010, 4'd2, 1'b0);
      push4("D", 3'b011, 4'd2, 1'b1);
      push_stat4(8);
      load4("DCBA", {4'd1, 4'd1, 4'd1, 4'd1});
      drain();

      // Skewed frequencies, full-depth codes
      push4("w", 3'b001, 4'd1, 1'b0);
      push4("x", 3'b001, 4'd2, 1'b0);
      push4("y", 3'b001, 4'd3, 1'b0);
      push4("z", 3'b000, 4'd3, 1'b1);
      push_stat4(25);
      load4("zyxw", {4'd1, 4'd2, 4'd4, 4'd8});
      drain();

      // Same batch under backpressure, with in_valid held while busy
      bp_en = 1'b1;
      push4("w", 3'b001, 4'd1, 1'b0);
      push4("x", 3'b001, 4'd2, 1'b0);
      push4("y", 3'b001, 4'd3, 1'b0);
      push4("z", 3'b000, 4'd3, 1'b1);
      push_stat4(25);
      load4("zyxw", {4'd1, 4'd2, 4'd4, 4'd8});
      in_valid4 = 1'b1; in_sym4 = 8'hEE; in_freq4 = 4'd7;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("busy_in_ready4", {31'b0, in_ready4}, 32'd0);
         chk("busy_flag4", {31'b0, busy4}, 32'd1);
      end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      drain();
      bp_en = 1'b0;
      @(posedge clk); #1;

      // Abort in the second WALK, then a fresh batch
      push4("w", 3'b001, 4'd1, 1'b0);
      push4("x", 3'b001, 4'd2, 1'b0);
      push4("y", 3'b001, 4'd3, 1'b0);
      push4("z", 3'b000, 4'd3, 1'b1);
      push_stat4(25);
      load4("zyxw", {4'd1, 4'd2, 4'd4, 4'd8});
      begin
         int g;
         g = 0;
         @(negedge clk);
         while (!(out_valid4 && out_ready4) && g < 300) begin @(negedge clk); g++; end
         chk("first_rec_timeout", (g >= 300) ? 32'd1 : 32'd0, 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset_vals("mid");
      @(posedge clk); #1;
      reset = 1'b0;
      q4.delete();
`ifdef HUFF_STATS_EN
      qs4.delete();
`endif
      push4("p", 3'b011, 4'd2, 1'b0);
      push4("q", 3'b000, 4'd1, 1'b0);
      push4("r", 3'b100, 4'd3, 1'b0);
      push4("s", 3'b101, 4'd3, 1'b1);
      push_stat4(15);
      load4("srqp", {4'd1, 4'd1, 4'd3, 4'd3});
      drain();

      // Back-to-back batches
      push4("A", 3'b000, 4'd2, 1'b0);
      push4("B", 3'b001, 4'd2, 1'b0);
      push4("C", 3'b010, 4'd2, 1'b0);
      push4("D", 3'b011, 4'd2, 1'b1);
      push_stat4(8);
      push4("p", 3'b011, 4'd2, 1'b0);
      push4("q", 3'b000, 4'd1, 1'b0);
      push4("r", 3'b100, 4'd3, 1'b0);
      push4("s", 3'b101, 4'd3, 1'b1);
      push_stat4(15);
      load4("DCBA", {4'd1, 4'd1, 4'd1, 4'd1});
      load4("srqp", {4'd1, 4'd1, 4'd3, 4'd3});
      drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
